shift_right_unit_seq: RTL and testbench
=======================================

Name: shift_right_unit_seq

Overview:
- Iterative, multi-cycle right shifter for the MIPS datapath. It is the companion to the left-shift unit and implements SRL/SRLV, plus SRA/SRAV when the optional feature is compiled in.
- Shifts one bit per clock under a start/done handshake. This trades latency for area ahead of the ALU result mux.
- The shift amount is 6 bits wide, matching the left-shift unit's amount width.

Parameters:
- WIDTH, 32, data width in bits.
- AMT_W, 6, shift-amount width in bits.
- CNT_W, 6, internal counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- in  input  WIDTH  operand to shift.
- shiftAmmount  input  AMT_W  shift distance, unsigned.
- arith  input  1  1 selects arithmetic shift (sign fill). Honoured only with SHIFT_ARITH_EN.
- out  output  WIDTH  result; registered; held until the next completion.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when out updates.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset (asynchronous, any state, including mid-shift):
  - state=IDLE, out=0, busy=0, done=0.
  - Internal data register and counter cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, SHIFT.
- IDLE:
  - On a clock edge with start=1: load data_reg<=in, cnt<=min(shiftAmmount, WIDTH), fill<=(arith & in[WIDTH-1]) when arithmetic is enabled, else 0.
  - Then busy<=1, state<=SHIFT.
  - With start=0 the block stays in IDLE and done is 0.
- SHIFT:
  - If cnt!=0: data_reg<={fill, data_reg[WIDTH-1:1]}, cnt<=cnt-1.
  - If cnt==0: out<=data_reg, done<=1, busy<=0, state<=IDLE.
- done timing:
  - done is high for exactly one cycle, then returns to 0 at the next edge.
  - It is never asserted in the same cycle as busy.
- Latency: done is observed high after eff+2 rising edges from the edge that samples start, where eff=min(shiftAmmount, WIDTH).
  - Minimum is 2 (shiftAmmount=0).
  - Maximum is WIDTH+2 (34 at default).
- Clamping: a shift of eff=WIDTH yields all zeros (logical) or all fill bits (arithmetic). Amounts 33..63 therefore give the same result as 32, with no extra cycles.
- start while busy=1 is ignored: no queuing, and the operation in progress is unaffected.
- start in the same cycle that done is high: accepted, since the state is IDLE.
- Operand capture: in, shiftAmmount and arith are captured only at the start edge. Changes afterwards do not affect the result.
- out keeps its previous value throughout SHIFT.
- Result equivalence: with fill=0 the result equals in >> eff. With fill=1 it equals the arithmetic shift of in.

Optional Feature:
- Macro: SHIFT_ARITH_EN.
- Defined: arith is honoured; fill is the operand's sign bit when arith=1, supporting SRA/SRAV.
- Undefined: arith is ignored and fill is hardwired to 0. Every operation is a logical shift and the sign-fill logic is not synthesised.
- The port list is identical in both builds.

Test Plan:
- in=0x80000000, shiftAmmount=4, arith=0, start pulse -> out=0x08000000; done pulses after 6 edges; busy high for the intervening cycles.
- Same stimulus with arith=1 and SHIFT_ARITH_EN defined -> out=0xF8000000. With the macro undefined -> out=0x08000000.
- in=100, shiftAmmount=0 -> out=100, done after 2 edges. Then in=100, shiftAmmount=2 -> out=25, done after 4 edges.
- in=0xFFFFFFFF, shiftAmmount=40, arith=0 -> out=0x00000000, done after 34 edges. With arith=1 (macro defined) -> out=0xFFFFFFFF.
- Start shift of in=0x00000F00 by 8, then pulse start again with in=0x1, shiftAmmount=0 while busy -> second request ignored; out=0x0000000F, exactly one done pulse.
- Start shift of 0x12345678 by 20; assert reset 5 cycles in, asynchronously between edges -> out=0, busy=0, done=0 immediately; no done after release. A new start then completes normally.

Source files
------------

// File: rtl/shift_right_unit_seq.sv
// Iterative right shifter: one bit per clock under a start/done handshake.
// Optional macro SHIFT_ARITH_EN enables arithmetic (sign-fill) shifts via arith.
module shift_right_unit_seq #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] shiftAmmount,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  // Handshake: start is sampled only in IDLE; busy is high from the start edge
  // until the result edge; done pulses for one cycle exactly when out updates.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cnt_load;
  logic               fill_load;

  // Amounts beyond WIDTH give the same result as WIDTH, so no extra cycles.
  assign cnt_load = (int'(shiftAmmount) > WIDTH) ? CNT_W'(WIDTH) : CNT_W'(shiftAmmount);

`ifdef SHIFT_ARITH_EN
  assign fill_load = arith & in[WIDTH-1];
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_load    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = in;
          cnt_d   = cnt_load;
          fill_d  = fill_load;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          data_d = {fill_q, data_q[WIDTH-1:1]};
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          out_d   = data_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_right_unit_seq.sv
// Directed bench for shift_right_unit_seq; arithmetic expectations follow SHIFT_ARITH_EN.
module tb_shift_right_unit_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_r;
  logic [5:0]  amt_r;
  logic        arith_r;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int          tests_run;
  int          tests_failed;
  logic [31:0] last_exp;

  shift_right_unit_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in           (in_r),
    .shiftAmmount (amt_r),
    .arith        (arith_r),
    .out          (out),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse, then scramble operands to prove they were captured.
  task automatic begin_op(input logic [31:0] a, input logic [5:0] amt, input logic ar);
    @(negedge clk);
    in_r    = a;
    amt_r   = amt;
    arith_r = ar;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    in_r    = $urandom;
    amt_r   = 6'($urandom_range(0, 63));
    arith_r = 1'($urandom_range(0, 1));
  endtask

  // Count edges until done, checking busy and held out on every non-done cycle.
  task automatic wait_done(input string tag, input int edges_in, output int edges_out);
    int   edges;
    logic seen;
    edges = edges_in;
    seen  = 1'b0;
    while (!seen && edges < 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold"}, out, last_exp);
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    edges_out = edges;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [5:0] amt,
                        input logic ar, input logic [31:0] exp, input int exp_edges);
    int edges;
    begin_op(a, amt, ar);
    wait_done(tag, 1, edges);
    check({tag, "_edges"}, 32'(edges), 32'(exp_edges));
    check({tag, "_out"}, out, exp);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int edges;
    int extra_done;
    tests_run    = 0;
    tests_failed = 0;
    last_exp     = 32'h0;
    reset        = 1'b1;
    start        = 1'b0;
    in_r         = 32'h0;
    amt_r        = 6'd0;
    arith_r      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("srl4", 32'h8000_0000, 6'd4, 1'b0, 32'h0800_0000, 6);
    @(posedge clk);
    #1;
    check("srl4_done_drop", 32'(done), 32'd0);

`ifdef SHIFT_ARITH_EN
    run_op("sra4", 32'h8000_0000, 6'd4, 1'b1, 32'hF800_0000, 6);
`else
    run_op("sra4", 32'h8000_0000, 6'd4, 1'b1, 32'h0800_0000, 6);
`endif

    run_op("amt0", 32'd100, 6'd0, 1'b0, 32'd100, 2);
    // Issued while done from the previous op is still high.
    run_op("amt2", 32'd100, 6'd2, 1'b0, 32'd25, 4);

    run_op("clamp_l", 32'hFFFF_FFFF, 6'd40, 1'b0, 32'h0000_0000, 34);
`ifdef SHIFT_ARITH_EN
    run_op("clamp_a", 32'hFFFF_FFFF, 6'd40, 1'b1, 32'hFFFF_FFFF, 34);
`else
    run_op("clamp_a", 32'hFFFF_FFFF, 6'd40, 1'b1, 32'h0000_0000, 34);
`endif
    run_op("amt32", 32'hA5A5_A5A5, 6'd32, 1'b0, 32'h0000_0000, 34);
    run_op("amt31", 32'hA5A5_A5A5, 6'd31, 1'b0, 32'h0000_0001, 33);

    // Second start while busy must be ignored.
    begin_op(32'h0000_0F00, 6'd8, 1'b0);
    @(negedge clk);
    in_r  = 32'h1;
    amt_r = 6'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_ign", 2, edges);
    check("busy_ign_edges", 32'(edges), 32'd10);
    check("busy_ign_out", out, 32'h0000_000F);
    last_exp   = 32'h0000_000F;
    extra_done = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("busy_ign_one_done", 32'(extra_done), 32'd0);
    check("busy_ign_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-shift discards the operation.
    begin_op(32'h1234_5678, 6'd20, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out", out, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    last_exp   = 32'h0;
    extra_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    check("arst_no_done", 32'(extra_done), 32'd0);
    check("arst_out_hold", out, 32'h0);

    run_op("post_rst", 32'h1234_5678, 6'd20, 1'b0, 32'h0000_0123, 22);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
